// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests a word at pc, holds it for decode until retire, then selects the next PC.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned next PC raises misalign and parks the unit in HALT until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned SEL_PC_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_ack,
    input  logic [31:0]             imem_rdata,
    output logic [31:0]             ir,
    output logic [31:0]             pc,
    output logic                    ir_valid,
    input  logic [31:0]             imm,
    input  logic [SEL_PC_WIDTH-1:0] pc_sel,
    input  logic                    br_taken,
    input  logic [31:0]             rs1_data,
    input  logic                    retire,
    output logic [31:0]             instret,
    output logic                    misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        HALT
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] instret_q, instret_d;
    logic        fresh_q, fresh_d;
    logic [31:0] target;
    logic [31:0] next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    always_comb begin
        target = pc_q + 32'd4;
        case (pc_sel)
            SEL_PC_WIDTH'(1): if (br_taken) target = pc_q + imm;
            SEL_PC_WIDTH'(2): target = pc_q + imm;
            SEL_PC_WIDTH'(3): target = (rs1_data + imm) & ~32'h1;
            default: ;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        next_pc = target;
`else
        // Without the trap, the low bits are cleared so fetches stay word aligned.
        next_pc = target & ~32'h3;
`endif
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        fresh_d   = 1'b0;
        imem_req  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            FETCH: begin
                // fresh_q keeps the first cycle after reset quiet, which also drops a late ack.
                if (!fresh_q) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_d    = imem_rdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (retire) begin
                    pc_d      = next_pc;
                    instret_d = instret_q + 32'd1;
                    state_d   = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= NOP;
            instret_q <= '0;
            fresh_q   <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            fresh_q   <= fresh_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_valid  = (state_q == HOLD);
    assign instret   = instret_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`else
    assign misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        ir_valid;
    logic [31:0] imm = '0;
    logic [1:0]  pc_sel = '0;
    logic        br_taken = 1'b0;
    logic [31:0] rs1_data = '0;
    logic        retire = 1'b0;
    logic [31:0] instret;
    logic        misalign;

    fetch_unit #(.RESET_PC(RESET_PC), .SEL_PC_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .pc(pc),
        .ir_valid(ir_valid), .imm(imm), .pc_sel(pc_sel), .br_taken(br_taken),
        .rs1_data(rs1_data), .retire(retire), .instret(instret), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned fails   = 0;

    // Reference model: where the unit is in its fetch/hold life cycle, as plain flags.
    bit          m_known = 0;
    bit          m_blank = 0;   // first cycle after a reset edge
    bit          m_valid = 0;   // an instruction is being held for decode
    bit          m_halt  = 0;
    bit          m_mis   = 0;
    logic [31:0] m_pc, m_ir, m_instret;
    logic [31:0] fetch_log[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] model_next(input logic [1:0] sel, input logic [31:0] imm_v,
                                               input bit br, input logic [31:0] rs1,
                                               input logic [31:0] cur);
        logic [31:0] t;
        case (sel)
            2'd0: t = cur + 32'd4;
            2'd1: t = br ? cur + imm_v : cur + 32'd4;
            2'd2: t = cur + imm_v;
            default: t = (rs1 + imm_v) & 32'hFFFF_FFFE;
        endcase
        return t;
    endfunction

    // One clock: compare outputs against the model, drive the next inputs, advance the model.
    task automatic step(input bit rn, input bit ack, input logic [31:0] rdata, input bit ret,
                        input logic [1:0] sel, input logic [31:0] imm_v, input bit br,
                        input logic [31:0] rs1);
        logic [31:0] t;
        @(negedge clk);
        if (m_known) begin
            check("imem_req", imem_req, {31'd0, !m_blank && !m_valid && !m_halt});
            if (!m_blank && !m_valid && !m_halt) check("imem_addr", imem_addr, m_pc);
            check("ir_valid", ir_valid, {31'd0, m_valid});
            check("pc", pc, m_pc);
            check("ir", ir, m_ir);
            check("instret", instret, m_instret);
            check("misalign", misalign, {31'd0, m_mis});
            if (imem_req === 1'b1) fetch_log.push_back(imem_addr);
        end
        rst_n = rn; imem_ack = ack; imem_rdata = rdata; retire = ret;
        pc_sel = sel; imm = imm_v; br_taken = br; rs1_data = rs1;
        if (!rn) begin
            m_known = 1; m_blank = 1; m_valid = 0; m_halt = 0; m_mis = 0;
            m_pc = RESET_PC; m_ir = NOP; m_instret = '0;
        end else if (m_blank) begin
            m_blank = 0;
        end else if (m_halt) begin
        end else if (!m_valid) begin
            if (ack) begin m_ir = rdata; m_valid = 1; end
        end else if (ret) begin
            t = model_next(sel, imm_v, br, rs1, m_pc);
            m_instret = m_instret + 32'd1;
            m_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc = t;
            if (t[1:0] != 2'b00) begin m_halt = 1; m_mis = 1; end
`else
            m_pc = t & 32'hFFFF_FFFC;
`endif
        end
    endtask

    task automatic idle(input bit rn);
        step(rn, 1'b0, '0, 1'b0, 2'd0, '0, 1'b0, '0);
    endtask

    // Zero-wait fetch of one instruction followed by its retire with the given next-PC controls.
    task automatic fetch_retire(input logic [1:0] sel, input logic [31:0] imm_v, input bit br,
                                input logic [31:0] rs1);
        bit done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            if (m_valid) begin
                step(1'b1, 1'b0, '0, 1'b1, sel, imm_v, br, rs1);
                done = 1;
            end else begin
                step(1'b1, 1'b1, NOP, 1'b0, 2'd0, '0, 1'b0, '0);
            end
        end
        check("fetch_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        idle(1'b0);
        peek();
        check("rst_req", imem_req, 32'd0);
        check("rst_valid", ir_valid, 32'd0);
        check("rst_ir", ir, NOP);
        check("rst_pc", pc, RESET_PC);
        check("rst_instret", instret, 32'd0);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd0, '0, 1'b0, '0);
        peek();
        check("resume_req", imem_req, 32'd1);
        check("resume_addr", imem_addr, RESET_PC);

        // Zero-wait sequential fetches
        fetch_log.delete();
        for (int i = 0; i < 4; i++) fetch_retire(2'd0, '0, 1'b1, '0);
        peek();
        check("seq_count", fetch_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("seq_addr", fetch_log[i], 32'(i * 4));
        check("seq_instret", instret, 32'd4);
        check("model_instret", m_instret, 32'd4);

        // Branch taken / not taken from 0x100
        fetch_retire(2'd2, 32'h0000_00F0, 1'b0, '0);
        peek();
        check("jal_addr", imem_addr, 32'h0000_0100);
        fetch_retire(2'd1, 32'hFFFF_FFF0, 1'b1, '0);
        peek();
        check("br_taken_addr", imem_addr, 32'h0000_00F0);
        check("model_br_taken", m_pc, 32'h0000_00F0);
        fetch_retire(2'd2, 32'h0000_0010, 1'b0, '0);
        fetch_retire(2'd1, 32'hFFFF_FFF0, 1'b0, '0);
        peek();
        check("br_not_taken_addr", imem_addr, 32'h0000_0104);

        // PC wrap at the top of the address space
        fetch_retire(2'd2, 32'hFFFF_FEF8, 1'b0, '0);
        peek();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch_retire(2'd0, '0, 1'b0, '0);
        peek();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("model_wrap", m_pc, 32'h0000_0000);

        // JALR to an odd target
        fetch_retire(2'd3, '0, 1'b0, 32'h0000_0203);
        peek();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("jalr_misalign", misalign, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, NOP, 1'b1, 2'd0, '0, 1'b0, '0);
            peek();
            check("halt_req", imem_req, 32'd0);
        end
`else
        check("jalr_addr", imem_addr, 32'h0000_0200);
        check("jalr_misalign", misalign, 32'd0);
`endif

        // Reset in the middle of a slow fetch; the late ack must be dropped
        idle(1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 2'd0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd0, '0, 1'b0, '0);
        peek();
        check("late_ack_ir", ir, NOP);
        check("late_ack_valid", ir_valid, 32'd0);
        check("restart_req", imem_req, 32'd1);
        check("restart_addr", imem_addr, RESET_PC);
        fetch_retire(2'd0, '0, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(63) != 0, $urandom_range(1) == 1, $urandom(),
                 $urandom_range(1) == 1, 2'($urandom_range(3)),
                 ($urandom_range(3) == 0) ? $urandom() : ($urandom() & 32'h0000_0FFC),
                 $urandom_range(1) == 1, $urandom());
        end
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
